// File: rtl/uart_rx_ctrl.sv
// Receive-side buffer for a UART: captures completed frames into a FWFT FIFO and tracks errors and overruns.
// Optional idle timeout flag is compiled in when UART_RX_CTRL_TIMEOUT_EN is defined.
module uart_rx_ctrl #(
  parameter int Depth         = 8,
  parameter int TimeoutCycles = 4096
) (
  input  logic                     clk,
  input  logic                     nReset,
  input  logic [7:0]               rxData,
  input  logic                     rxDone,
  input  logic                     rxErr,
  output logic [7:0]               outData,
  output logic                     outValid,
  input  logic                     outReady,
  output logic [$clog2(Depth):0]   count,
  output logic                     overrun,
  output logic [7:0]               errCount,
  input  logic                     clearStatus,
`ifdef UART_RX_CTRL_TIMEOUT_EN
  output logic                     timeout,
`endif
  output logic                     fsm_state_dbg
);

  localparam int AW = $clog2(Depth);
  localparam int CW = AW + 1;

  typedef enum logic {
    IDLE    = 1'b0,
    CAPTURE = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            overrun_q, overrun_d;
  logic [7:0]      err_cnt_q, err_cnt_d;
  logic [7:0]      mem_q [Depth];

  logic push_req;
  logic full;
  logic empty;
  logic pop;
  logic do_push;
  logic drop;

  // The byte is sampled in the cycle after rxDone, i.e. while in CAPTURE.
  assign push_req = (state_q == CAPTURE);
  assign full     = (count_q == CW'(Depth));
  assign empty    = (count_q == '0);
  assign pop      = !empty && outReady;
  assign do_push  = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  always_comb begin
    state_d   = IDLE;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = drop || (overrun_q && !clearStatus);
    err_cnt_d = err_cnt_q;

    if (rxDone && !rxErr) begin
      state_d = CAPTURE;
    end

    if (do_push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    case ({do_push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // A same-cycle error pulse beats the clear so no event is lost.
    if (clearStatus) begin
      err_cnt_d = {7'b0, rxErr};
    end else if (rxErr && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
      err_cnt_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= rxData;
    end
  end

  assign outData       = empty ? 8'h00 : mem_q[rd_ptr_q];
  assign outValid      = !empty;
  assign count         = count_q;
  assign overrun       = overrun_q;
  assign errCount      = err_cnt_q;
  assign fsm_state_dbg = state_q;

`ifdef UART_RX_CTRL_TIMEOUT_EN
  localparam logic [15:0] TmoMax = 16'(TimeoutCycles);

  logic [15:0] tmo_q, tmo_d;

  always_comb begin
    tmo_d = tmo_q;
    if (push_req || empty) begin
      tmo_d = 16'd0;
    end else if (tmo_q != TmoMax) begin
      tmo_d = tmo_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      tmo_q <= 16'd0;
    end else begin
      tmo_q <= tmo_d;
    end
  end

  assign timeout = (tmo_q == TmoMax) && !empty;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl (Depth=8); timeout steps run when UART_RX_CTRL_TIMEOUT_EN is defined.
module tb_uart_rx_ctrl;

  logic       clk = 1'b0;
  logic       nReset;
  logic [7:0] rxData;
  logic       rxDone;
  logic       rxErr;
  logic [7:0] outData;
  logic       outValid;
  logic       outReady;
  logic [3:0] count;
  logic       overrun;
  logic [7:0] errCount;
  logic       clearStatus;
  logic       fsm_state_dbg;
`ifdef UART_RX_CTRL_TIMEOUT_EN
  logic       timeout;
`endif

  int total = 0;
  int bad   = 0;

  uart_rx_ctrl #(.Depth(8), .TimeoutCycles(16)) dut (
    .clk(clk),
    .nReset(nReset),
    .rxData(rxData),
    .rxDone(rxDone),
    .rxErr(rxErr),
    .outData(outData),
    .outValid(outValid),
    .outReady(outReady),
    .count(count),
    .overrun(overrun),
    .errCount(errCount),
    .clearStatus(clearStatus),
`ifdef UART_RX_CTRL_TIMEOUT_EN
    .timeout(timeout),
`endif
    .fsm_state_dbg(fsm_state_dbg)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    rxData = b;
    rxDone = 1'b1;
    tick();
    rxDone = 1'b0;
    tick();
  endtask

  task automatic pop_one();
    outReady = 1'b1;
    tick();
    outReady = 1'b0;
  endtask

  initial begin
    nReset = 1'b0; rxData = 8'h00; rxDone = 1'b0; rxErr = 1'b0;
    outReady = 1'b0; clearStatus = 1'b0;
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(outValid), 32'd0);
    chk("rst_data", 32'(outData), 32'h00);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_errcnt", 32'(errCount), 32'd0);
    chk("rst_state", 32'(fsm_state_dbg), 32'd0);
    tick(); tick();
    nReset = 1'b1;
    tick();

    // First byte: visible two edges after the rxDone pulse.
    rxData = 8'hA5; rxDone = 1'b1;
    tick();
    rxDone = 1'b0;
    chk("a5_state_capture", 32'(fsm_state_dbg), 32'd1);
    chk("a5_not_yet_valid", 32'(outValid), 32'd0);
    tick();
    chk("a5_valid", 32'(outValid), 32'd1);
    chk("a5_data", 32'(outData), 32'hA5);
    chk("a5_count", 32'(count), 32'd1);
    chk("a5_state_idle", 32'(fsm_state_dbg), 32'd0);
    pop_one();
    chk("a5_pop_count", 32'(count), 32'd0);
    chk("a5_pop_valid", 32'(outValid), 32'd0);
    chk("empty_data_zero", 32'(outData), 32'h00);

    outReady = 1'b1;
    tick();
    outReady = 1'b0;
    chk("pop_empty_count", 32'(count), 32'd0);

    // Nine bytes into eight entries: last one dropped.
    for (int i = 1; i <= 9; i++) push_byte(8'(i));
    chk("full_count", 32'(count), 32'd8);
    chk("full_overrun", 32'(overrun), 32'd1);
    clearStatus = 1'b1;
    tick();
    clearStatus = 1'b0;
    chk("clear_overrun", 32'(overrun), 32'd0);
    chk("clear_keeps_count", 32'(count), 32'd8);
    outReady = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("drain_%0d", i), 32'(outData), 32'(i));
      tick();
    end
    outReady = 1'b0;
    chk("drain_count", 32'(count), 32'd0);

    // Full FIFO with same-cycle pop and push.
    for (int i = 0; i < 8; i++) push_byte(8'h10 + 8'(i));
    rxData = 8'h55; rxDone = 1'b1;
    tick();
    rxDone = 1'b0; outReady = 1'b1;
    tick();
    outReady = 1'b0;
    chk("pp_full_count", 32'(count), 32'd8);
    chk("pp_full_overrun", 32'(overrun), 32'd0);
    outReady = 1'b1;
    for (int i = 1; i < 8; i++) begin
      chk($sformatf("pp_drain_%0d", i), 32'(outData), 32'(8'h10 + 8'(i)));
      tick();
    end
    chk("pp_last_55", 32'(outData), 32'h55);
    tick();
    outReady = 1'b0;
    chk("pp_empty", 32'(outValid), 32'd0);

    // Error wins over rxDone in the same cycle.
    push_byte(8'h33);
    rxData = 8'hFF; rxDone = 1'b1; rxErr = 1'b1;
    tick();
    rxDone = 1'b0; rxErr = 1'b0;
    chk("errdone_state", 32'(fsm_state_dbg), 32'd0);
    tick();
    chk("errdone_count", 32'(count), 32'd1);
    chk("errdone_errcnt", 32'(errCount), 32'd1);
    chk("errdone_head", 32'(outData), 32'h33);
    pop_one();

    // Saturation and clear-vs-error priority.
    for (int i = 0; i < 300; i++) begin
      rxErr = 1'b1;
      tick();
      rxErr = 1'b0;
      tick();
    end
    chk("err_saturated", 32'(errCount), 32'd255);
    clearStatus = 1'b1; rxErr = 1'b1;
    tick();
    clearStatus = 1'b0; rxErr = 1'b0;
    chk("err_clear_with_err", 32'(errCount), 32'd1);
    clearStatus = 1'b1;
    tick();
    clearStatus = 1'b0;
    chk("err_clear", 32'(errCount), 32'd0);

    // Overrun in the same cycle as clearStatus stays set.
    for (int i = 0; i < 8; i++) push_byte(8'h40 + 8'(i));
    rxData = 8'h99; rxDone = 1'b1;
    tick();
    rxDone = 1'b0; clearStatus = 1'b1;
    tick();
    clearStatus = 1'b0;
    chk("ovr_clear_win", 32'(overrun), 32'd1);
    chk("ovr_head_kept", 32'(outData), 32'h40);

    // Reset during CAPTURE discards the pending byte.
    rxData = 8'h77; rxDone = 1'b1;
    tick();
    rxDone = 1'b0;
    chk("midcap_state", 32'(fsm_state_dbg), 32'd1);
    nReset = 1'b0;
    #1;
    chk("midcap_rst_count", 32'(count), 32'd0);
    chk("midcap_rst_data", 32'(outData), 32'h00);
    chk("midcap_rst_overrun", 32'(overrun), 32'd0);
    chk("midcap_rst_state", 32'(fsm_state_dbg), 32'd0);
    tick();
    nReset = 1'b1;
    tick(); tick();
    chk("midcap_no_push", 32'(count), 32'd0);

    push_byte(8'hC3);
    chk("post_rst_push", 32'(outData), 32'hC3);

`ifdef UART_RX_CTRL_TIMEOUT_EN
    chk("tmo_after_push", 32'(timeout), 32'd0);
    for (int i = 0; i < 15; i++) tick();
    chk("tmo_15_idle", 32'(timeout), 32'd0);
    tick();
    chk("tmo_16_idle", 32'(timeout), 32'd1);
    pop_one();
    chk("tmo_after_pop", 32'(timeout), 32'd0);
`else
    pop_one();
    chk("final_empty", 32'(outValid), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
